// File: rtl/sid_adsr_multi_if.sv
// Envelope-generator control/observe bundle: per-voice gate, ADSR nibbles and mode in;
// registered per-voice level, state and done pulse out. No flow control.
interface sid_adsr_multi_if #(
    parameter int VOICES = 3,
    parameter int ENV_W  = 8
);
    logic [VOICES-1:0]       gate;
    logic [4*VOICES-1:0]     attack_rate;
    logic [4*VOICES-1:0]     decay_rate;
    logic [4*VOICES-1:0]     sustain_value;
    logic [4*VOICES-1:0]     release_rate;
    logic [VOICES-1:0]       exp_mode;
    logic [ENV_W*VOICES-1:0] env_out;
    logic [3*VOICES-1:0]     env_state;
    logic [VOICES-1:0]       env_done;

    modport master (
        output gate, attack_rate, decay_rate, sustain_value, release_rate, exp_mode,
        input  env_out, env_state, env_done
    );

    modport slave (
        input  gate, attack_rate, decay_rate, sustain_value, release_rate, exp_mode,
        output env_out, env_state, env_done
    );
endinterface

// File: rtl/sid_adsr_multi.sv
// Multi-voice ADSR envelope generator sharing one free-running prescaler; gate edge to state
// change is two clocks, level steps appear the clock after their tick; no backpressure.
module sid_adsr_multi #(
    parameter int VOICES    = 3,
    parameter int ENV_W     = 8,
    parameter int RATE_BASE = 9,
    parameter int PRE_W     = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    sid_adsr_multi_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    typedef struct packed {
        state_t           st;
        logic [ENV_W-1:0] env;
        logic [3:0]       ec;
        logic             done;
    } voice_t;

    localparam logic [ENV_W-1:0] ENV_MAX = '1;
    localparam int               REPS    = (ENV_W + 3) / 4;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [VOICES-1:0] gate_q, gate_d;
    logic [VOICES-1:0] gate_prev_q, gate_prev_d;
    logic [1:0]        armed_q, armed_d;
    voice_t            voice_q [VOICES];
    voice_t            voice_d [VOICES];

    logic [ENV_W*VOICES-1:0] env_out_w;
    logic [3*VOICES-1:0]     env_state_w;
    logic [VOICES-1:0]       env_done_w;

    function automatic logic rate_tick(input logic [PRE_W-1:0] pre, input logic [3:0] r);
        logic [PRE_W-1:0] mask;
        mask = (PRE_W'(1) << (int'(r) + RATE_BASE)) - PRE_W'(1);
        return (pre & mask) == mask;
    endfunction

    function automatic logic [ENV_W-1:0] sus_level(input logic [3:0] nib);
        logic [4*REPS-1:0] rep;
        rep = {REPS{nib}};
        return rep[4*REPS-1 -: ENV_W];
    endfunction

    // Exponential divider minus one, chosen from the top three level bits.
    function automatic logic [3:0] exp_div_m1(input logic [ENV_W-1:0] env);
        logic [2:0] m;
        m = env[ENV_W-1 -: 3];
        if (m >= 3'd6)      return 4'd0;
        else if (m >= 3'd4) return 4'd1;
        else if (m >= 3'd2) return 4'd3;
        else if (m == 3'd1) return 4'd7;
        else                return 4'd15;
    endfunction

    function automatic voice_t voice_next(
        input voice_t           cur,
        input logic             gate_lvl,
        input logic             rise,
        input logic [3:0]       a_r,
        input logic [3:0]       d_r,
        input logic [3:0]       s_n,
        input logic [3:0]       r_r,
        input logic             expm,
        input logic [PRE_W-1:0] pre
    );
        voice_t           nxt;
        logic [3:0]       rate;
        logic             tk;
        logic             stp;
        logic [3:0]       ec_adv;
        logic [ENV_W-1:0] lvl;
        nxt      = cur;
        nxt.done = 1'b0;
        lvl      = sus_level(s_n);
        case (cur.st)
            ATTACK:  rate = a_r;
            DECAY:   rate = d_r;
            default: rate = r_r;
        endcase
        tk     = rate_tick(pre, rate);
        stp    = 1'b0;
        ec_adv = cur.ec;
        if (tk) begin
            if (!expm || cur.ec == exp_div_m1(cur.env)) begin
                stp    = 1'b1;
                ec_adv = 4'd0;
            end else begin
                ec_adv = cur.ec + 4'd1;
            end
        end
        if (rise) begin
            nxt.st = ATTACK;
            nxt.ec = 4'd0;
        end else if (!gate_lvl && (cur.st == ATTACK || cur.st == DECAY || cur.st == SUSTAIN)) begin
            nxt.st = RELEASE;
            nxt.ec = 4'd0;
        end else begin
            case (cur.st)
                IDLE: nxt.env = '0;
                ATTACK: begin
                    if (cur.env == ENV_MAX) begin
                        nxt.st = DECAY;
                        nxt.ec = 4'd0;
                    end else if (tk) begin
                        nxt.env = cur.env + ENV_W'(1);
                    end
                end
                DECAY: begin
                    if (cur.env <= lvl) begin
                        nxt.st = SUSTAIN;
                        nxt.ec = 4'd0;
                    end else begin
                        nxt.ec = ec_adv;
                        if (stp) nxt.env = cur.env - ENV_W'(1);
                    end
                end
                // A lowered sustain pulls the level down; a raised one never lifts it.
                SUSTAIN: begin
                    if (cur.env > lvl) begin
                        nxt.st = DECAY;
                        nxt.ec = 4'd0;
                    end
                end
                RELEASE: begin
                    if (cur.env == '0) begin
                        nxt.st   = IDLE;
                        nxt.ec   = 4'd0;
                        nxt.done = 1'b1;
                    end else begin
                        nxt.ec = ec_adv;
                        if (stp) nxt.env = cur.env - ENV_W'(1);
                    end
                end
                default: begin
                    nxt.st  = IDLE;
                    nxt.env = '0;
                    nxt.ec  = 4'd0;
                end
            endcase
        end
        return nxt;
    endfunction

    // armed_q[1] marks gate_prev_q as a real sample, so a gate held through reset is not an edge.
    always_comb begin
        pre_d       = pre_q + PRE_W'(1);
        gate_d      = bus.gate;
        gate_prev_d = gate_q;
        armed_d     = {armed_q[0], 1'b1};
        for (int v = 0; v < VOICES; v++) begin
            voice_d[v] = voice_next(voice_q[v], gate_q[v],
                                    gate_q[v] & ~gate_prev_q[v] & armed_q[1],
                                    bus.attack_rate[4*v +: 4], bus.decay_rate[4*v +: 4],
                                    bus.sustain_value[4*v +: 4], bus.release_rate[4*v +: 4],
                                    bus.exp_mode[v], pre_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            gate_q      <= '0;
            gate_prev_q <= '0;
            armed_q     <= '0;
            for (int v = 0; v < VOICES; v++) voice_q[v] <= '0;
        end else begin
            pre_q       <= pre_d;
            gate_q      <= gate_d;
            gate_prev_q <= gate_prev_d;
            armed_q     <= armed_d;
            for (int v = 0; v < VOICES; v++) voice_q[v] <= voice_d[v];
        end
    end

    always_comb begin
        env_out_w   = '0;
        env_state_w = '0;
        env_done_w  = '0;
        for (int v = 0; v < VOICES; v++) begin
            env_out_w[v*ENV_W +: ENV_W] = voice_q[v].env;
            env_state_w[3*v +: 3]       = voice_q[v].st;
            env_done_w[v]               = voice_q[v].done;
        end
    end

    assign bus.env_out   = env_out_w;
    assign bus.env_state = env_state_w;
    assign bus.env_done  = env_done_w;

endmodule
